// File: rtl/receive_from_fx2lp_if.sv
// Pin-level bundle for receive_from_fx2lp: FX2LP slave-FIFO read side plus the
// Avalon-ST word source and the delivered-word counter.
interface receive_from_fx2lp_if #(
    parameter int unsigned COUNT_WIDTH = 32
);
    logic [31:0]            aso_out0_data;
    logic                   aso_out0_valid;
    logic                   aso_out0_ready;
    logic [7:0]             coe_fx2lp_fd;
    logic                   coe_fx2lp_slrd_n;
    logic                   coe_fx2lp_slwr_n;
    logic                   coe_fx2lp_flaga_n;
    logic                   coe_fx2lp_sloe_n;
    logic [1:0]             coe_fx2lp_fifoadr;
    logic                   coe_fx2lp_pktend_n;
    logic [COUNT_WIDTH-1:0] stat_words;

    modport master (
        output aso_out0_data, aso_out0_valid,
        input  aso_out0_ready,
        input  coe_fx2lp_fd, coe_fx2lp_flaga_n,
        output coe_fx2lp_slrd_n, coe_fx2lp_slwr_n, coe_fx2lp_sloe_n,
        output coe_fx2lp_fifoadr, coe_fx2lp_pktend_n,
        output stat_words
    );

    modport slave (
        input  aso_out0_data, aso_out0_valid,
        output aso_out0_ready,
        output coe_fx2lp_fd, coe_fx2lp_flaga_n,
        input  coe_fx2lp_slrd_n, coe_fx2lp_slwr_n, coe_fx2lp_sloe_n,
        input  coe_fx2lp_fifoadr, coe_fx2lp_pktend_n,
        input  stat_words
    );
endinterface

// File: rtl/receive_from_fx2lp.sv
// Reads bytes from the FX2LP slave FIFO (sync, 8-bit) and emits little-endian
// 32-bit words on an Avalon-ST source, throttled by FIFO-empty and backpressure.
module receive_from_fx2lp #(
    parameter logic [1:0]  FIFO_ADDR   = 2'b10,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input logic                  csi_clk,
    input logic                  rsi_reset,
    receive_from_fx2lp_if.master bus
);
    typedef enum logic {IDLE, ACC} state_t;

    state_t                 state_q, state_d;
    logic [1:0]             byte_idx_q, byte_idx_d;
    logic [23:0]            lanes_q, lanes_d;
    logic [31:0]            data_q, data_d;
    logic                   valid_q, valid_d;
    logic [COUNT_WIDTH-1:0] words_q, words_d;
    logic                   slot_free;
    logic                   rd_en;

    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            state_q    <= IDLE;
            byte_idx_q <= '0;
            lanes_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            words_q    <= '0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            lanes_q    <= lanes_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            words_q    <= words_d;
        end
    end

    // A consumed word is replaced on the same edge when the lane-3 byte lands.
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        lanes_d    = lanes_q;
        data_d     = data_q;
        valid_d    = valid_q;
        words_d    = words_q;
        if (valid_q && bus.aso_out0_ready) begin
            valid_d = 1'b0;
        end
        if (rd_en) begin
            byte_idx_d = byte_idx_q + 2'd1;
            case (state_q)
                IDLE:    state_d = ACC;
                ACC:     if (byte_idx_q == 2'd3) state_d = IDLE;
                default: state_d = IDLE;
            endcase
            case (byte_idx_q)
                2'd0: lanes_d[7:0]   = bus.coe_fx2lp_fd;
                2'd1: lanes_d[15:8]  = bus.coe_fx2lp_fd;
                2'd2: lanes_d[23:16] = bus.coe_fx2lp_fd;
                default: begin
                    data_d  = {bus.coe_fx2lp_fd, lanes_q};
                    valid_d = 1'b1;
                    words_d = words_q + COUNT_WIDTH'(1);
                end
            endcase
        end
    end

    // Lanes 0-2 keep filling under backpressure; only the word-closing read waits.
    always_comb begin
        slot_free            = ~valid_q | bus.aso_out0_ready;
        rd_en                = bus.coe_fx2lp_flaga_n & ((byte_idx_q != 2'd3) | slot_free);
        bus.coe_fx2lp_slrd_n = rsi_reset | ~rd_en;
        bus.coe_fx2lp_sloe_n = rsi_reset;
        bus.aso_out0_data    = data_q;
        bus.aso_out0_valid   = valid_q;
        bus.stat_words       = words_q;
    end

    assign bus.coe_fx2lp_slwr_n   = 1'b1;
    assign bus.coe_fx2lp_pktend_n = 1'b1;
    assign bus.coe_fx2lp_fifoadr  = FIFO_ADDR;
endmodule

// File: tb/tb_receive_from_fx2lp.sv
// Randomised bench for receive_from_fx2lp: an FX2LP FIFO model feeds bytes and a
// byte-grouping reference predicts strobes, words, valid timing and counters.
module tb_receive_from_fx2lp;
    logic clk;
    logic rst;

    receive_from_fx2lp_if #(.COUNT_WIDTH(32)) bus ();
    receive_from_fx2lp_if #(.COUNT_WIDTH(4))  bus4 ();

    receive_from_fx2lp #(.FIFO_ADDR(2'b10), .COUNT_WIDTH(32)) dut (
        .csi_clk(clk), .rsi_reset(rst), .bus(bus.master)
    );
    receive_from_fx2lp #(.FIFO_ADDR(2'b10), .COUNT_WIDTH(4)) dut4 (
        .csi_clk(clk), .rsi_reset(rst), .bus(bus4.master)
    );

    logic [7:0] fd_v;
    logic       flaga_v;
    logic       ready_v;

    assign bus.coe_fx2lp_fd       = fd_v;
    assign bus.coe_fx2lp_flaga_n  = flaga_v;
    assign bus.aso_out0_ready     = ready_v;
    assign bus4.coe_fx2lp_fd      = fd_v;
    assign bus4.coe_fx2lp_flaga_n = flaga_v;
    assign bus4.aso_out0_ready    = ready_v;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned errors;
    int unsigned checks;

    // FX2LP FIFO contents and reference model state
    logic [7:0]  src_q[$];
    logic [7:0]  part[$];
    logic [31:0] delivered[$];
    bit          pause;
    bit          exp_valid;
    logic [31:0] exp_data;
    int unsigned words_done;
    int unsigned handshakes;
    bit          last_rd;

    task automatic reset_model();
        src_q.delete();
        part.delete();
        delivered.delete();
        exp_valid  = 1'b0;
        exp_data   = '0;
        words_done = 0;
        handshakes = 0;
        pause      = 1'b0;
    endtask

    task automatic drive_pins();
        fd_v    = (src_q.size() > 0) ? src_q[0] : 8'h00;
        flaga_v = (src_q.size() > 0) && !pause;
    endtask

    // One clock: called just after a falling edge, returns just after the next one.
    task automatic cycle();
        bit exp_rd;
        bit xfer;
        logic [7:0] b;
        drive_pins();
        #1;
        exp_rd  = flaga_v && ((part.size() != 3) || !exp_valid || ready_v);
        last_rd = (bus.coe_fx2lp_slrd_n === 1'b0);
        checks++;
        if (last_rd !== exp_rd) begin
            errors++;
            $display("FAIL slrd_n: got rd=%0b expected rd=%0b at %0t", last_rd, exp_rd, $time);
        end
        checks++;
        if (bus.aso_out0_valid !== exp_valid) begin
            errors++;
            $display("FAIL valid: got %0b expected %0b at %0t", bus.aso_out0_valid, exp_valid, $time);
        end
        if (exp_valid) begin
            checks++;
            if (bus.aso_out0_data !== exp_data) begin
                errors++;
                $display("FAIL data: got %h expected %h at %0t", bus.aso_out0_data, exp_data, $time);
            end
        end
        checks++;
        if ({bus.coe_fx2lp_sloe_n, bus.coe_fx2lp_slwr_n, bus.coe_fx2lp_pktend_n,
             bus.coe_fx2lp_fifoadr} !== 5'b0_1_1_10) begin
            errors++;
            $display("FAIL static_pins: got sloe=%b slwr=%b pktend=%b fifoadr=%b expected 0 1 1 10",
                     bus.coe_fx2lp_sloe_n, bus.coe_fx2lp_slwr_n, bus.coe_fx2lp_pktend_n,
                     bus.coe_fx2lp_fifoadr);
        end
        xfer = exp_valid && ready_v;
        if (xfer) begin
            delivered.push_back(exp_data);
            handshakes++;
        end
        @(posedge clk);
        @(negedge clk);
        if (exp_rd) begin
            b = src_q.pop_front();
            part.push_back(b);
        end
        if (part.size() == 4) begin
            exp_data  = {part[3], part[2], part[1], part[0]};
            exp_valid = 1'b1;
            words_done++;
            part.delete();
        end else if (xfer) begin
            exp_valid = 1'b0;
        end
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cycle();
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        ready_v = 1'b1;
        reset_model();
        drive_pins();
        @(negedge clk);
        #1;
        checks++;
        if ({bus.aso_out0_valid, bus.coe_fx2lp_slrd_n, bus.coe_fx2lp_sloe_n} !== 3'b011) begin
            errors++;
            $display("FAIL reset_pins: got valid=%b slrd_n=%b sloe_n=%b expected 0 1 1",
                     bus.aso_out0_valid, bus.coe_fx2lp_slrd_n, bus.coe_fx2lp_sloe_n);
        end
        checks++;
        if (bus.aso_out0_data !== 32'h0 || bus.stat_words !== 32'h0 || bus4.stat_words !== 4'h0) begin
            errors++;
            $display("FAIL reset_regs: got data=%h stat=%0d stat4=%0d expected 0 0 0",
                     bus.aso_out0_data, bus.stat_words, bus4.stat_words);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_stream();
        int unsigned run_len;
        int unsigned best;
        test_reset();
        for (int unsigned i = 1; i <= 8; i++) src_q.push_back(8'(i * 8'h11));
        run_len = 0;
        best    = 0;
        for (int unsigned i = 0; i < 12; i++) begin
            cycle();
            run_len = last_rd ? run_len + 1 : 0;
            if (run_len > best) best = run_len;
        end
        checks++;
        if (best !== 8) begin
            errors++;
            $display("FAIL stream_strobe_run: got %0d expected 8", best);
        end
        checks++;
        if (delivered.size() !== 2 || delivered[0] !== 32'h44332211 || delivered[1] !== 32'h88776655) begin
            errors++;
            $display("FAIL stream_words: got n=%0d w0=%h w1=%h expected 2 44332211 88776655",
                     delivered.size(), delivered[0], delivered[1]);
        end
        checks++;
        if (bus.stat_words !== 32'd2) begin
            errors++;
            $display("FAIL stream_stat: got %0d expected 2", bus.stat_words);
        end
    endtask

    task automatic test_empty_pause();
        int unsigned idle;
        test_reset();
        src_q.push_back(8'hAA);
        src_q.push_back(8'hBB);
        run(2);
        pause = 1'b1;
        src_q.push_back(8'hCC);
        src_q.push_back(8'hDD);
        idle = 0;
        for (int unsigned i = 0; i < 5; i++) begin
            cycle();
            if (!last_rd) idle++;
        end
        checks++;
        if (idle !== 5) begin
            errors++;
            $display("FAIL pause_idle: got %0d idle cycles expected 5", idle);
        end
        pause = 1'b0;
        run(4);
        checks++;
        if (delivered.size() !== 1 || delivered[0] !== 32'hDDCCBBAA) begin
            errors++;
            $display("FAIL pause_word: got n=%0d w=%h expected 1 ddccbbaa", delivered.size(), delivered[0]);
        end
    endtask

    task automatic test_backpressure();
        test_reset();
        ready_v = 1'b0;
        for (int unsigned i = 1; i <= 8; i++) src_q.push_back(8'(i));
        run(11);
        checks++;
        if (bus.aso_out0_valid !== 1'b1 || bus.aso_out0_data !== 32'h04030201 ||
            src_q.size() !== 1 || last_rd !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: got valid=%b data=%h left=%0d rd=%b expected 1 04030201 1 0",
                     bus.aso_out0_valid, bus.aso_out0_data, src_q.size(), last_rd);
        end
        ready_v = 1'b1;
        cycle();
        checks++;
        if (last_rd !== 1'b1 || delivered.size() !== 1 || delivered[0] !== 32'h04030201) begin
            errors++;
            $display("FAIL bp_release: got rd=%b n=%0d w=%h expected 1 1 04030201",
                     last_rd, delivered.size(), delivered[0]);
        end
        #1;
        checks++;
        if (bus.aso_out0_valid !== 1'b1 || bus.aso_out0_data !== 32'h08070605) begin
            errors++;
            $display("FAIL bp_second: got valid=%b data=%h expected 1 08070605",
                     bus.aso_out0_valid, bus.aso_out0_data);
        end
        run(2);
    endtask

    task automatic test_back_to_back();
        logic [7:0]  sent[$];
        logic [31:0] w;
        int unsigned bad;
        test_reset();
        for (int unsigned i = 0; i < 40; i++) begin
            sent.push_back(8'($urandom));
            src_q.push_back(sent[i]);
        end
        for (int unsigned i = 0; i < 200 && (src_q.size() > 0 || exp_valid || part.size() > 0); i++) begin
            ready_v = (i % 2 == 0);
            pause   = ($urandom_range(0, 7) == 0);
            cycle();
        end
        pause   = 1'b0;
        ready_v = 1'b1;
        run(3);
        checks++;
        if (delivered.size() !== 10) begin
            errors++;
            $display("FAIL b2b_count: got %0d words expected 10", delivered.size());
        end
        bad = 0;
        for (int unsigned k = 0; k < 10 && k < delivered.size(); k++) begin
            w = {sent[4*k+3], sent[4*k+2], sent[4*k+1], sent[4*k]};
            if (delivered[k] !== w) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL b2b_order: got %0d wrong words expected 0", bad);
        end
        checks++;
        if (bus.stat_words !== 32'(handshakes) || handshakes !== 10) begin
            errors++;
            $display("FAIL b2b_stat: got stat=%0d handshakes=%0d expected 10 10", bus.stat_words, handshakes);
        end
    endtask

    task automatic test_reset_midword();
        test_reset();
        ready_v = 1'b0;
        for (int unsigned i = 0; i < 7; i++) src_q.push_back(8'hE0 + 8'(i));
        run(9);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.aso_out0_valid, bus.coe_fx2lp_slrd_n, bus.coe_fx2lp_sloe_n} !== 3'b011) begin
            errors++;
            $display("FAIL async_reset: got valid=%b slrd_n=%b sloe_n=%b expected 0 1 1",
                     bus.aso_out0_valid, bus.coe_fx2lp_slrd_n, bus.coe_fx2lp_sloe_n);
        end
        reset_model();
        ready_v = 1'b1;
        drive_pins();
        @(negedge clk);
        rst = 1'b0;
        for (int unsigned i = 1; i <= 4; i++) src_q.push_back(8'(i));
        run(6);
        checks++;
        if (delivered.size() !== 1 || delivered[0] !== 32'h04030201) begin
            errors++;
            $display("FAIL reset_realign: got n=%0d w=%h expected 1 04030201", delivered.size(), delivered[0]);
        end
    endtask

    task automatic test_stat_wrap();
        test_reset();
        for (int unsigned i = 0; i < 64; i++) src_q.push_back(8'($urandom));
        run(70);
        checks++;
        if (bus4.stat_words !== 4'd0 || bus.stat_words !== 32'd16 || words_done !== 16) begin
            errors++;
            $display("FAIL stat_wrap: got stat4=%0d stat32=%0d model=%0d expected 0 16 16",
                     bus4.stat_words, bus.stat_words, words_done);
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        rst     = 1'b1;
        ready_v = 1'b1;
        fd_v    = 8'h00;
        flaga_v = 1'b0;
        last_rd = 1'b0;
        test_reset();
        test_stream();
        test_empty_pause();
        test_backpressure();
        test_back_to_back();
        test_reset_midword();
        test_stat_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/receive_from_fx2lp.md
Name: receive_from_fx2lp

Overview:
- Inverse of the FX2LP transmit path: pulls bytes from the FX2LP slave FIFO (synchronous mode, 8-bit bus) and assembles them little-endian into 32-bit words.
- Presents the words on an Avalon-ST source.
- Sits in the Qsys core between the FX2LP pins and downstream stream consumers (e.g. the TX/DAC path, or a control-word parser).
- Read strobes are throttled by both the FX2LP empty flag and Avalon-ST backpressure, so no byte is lost or duplicated.

Parameters:
- FIFO_ADDR, 2'b10, value driven on coe_fx2lp_fifoadr (endpoint configured as OUT in FX2LP firmware).
- COUNT_WIDTH, 32, width of the received-word counter.

Ports:
- csi_clk  in  1  IFCLK-domain clock; all logic on rising edge.
- rsi_reset  in  1  asynchronous, active-high reset.
- aso_out0_data  out  32  assembled word; byte0 in [7:0], byte3 in [31:24].
- aso_out0_valid  out  1  word valid.
- aso_out0_ready  in  1  sink ready; readyLatency 0.
- coe_fx2lp_fd  in  8  FX2LP FIFO data bus.
- coe_fx2lp_slrd_n  out  1  read strobe, active low.
- coe_fx2lp_slwr_n  out  1  tied 1.
- coe_fx2lp_flaga_n  in  1  FIFO empty flag, active low (0 = empty).
- coe_fx2lp_sloe_n  out  1  output enable, active low.
- coe_fx2lp_fifoadr  out  2  = FIFO_ADDR.
- coe_fx2lp_pktend_n  out  1  tied 1.
- stat_words  out  COUNT_WIDTH  count of words delivered on the source.

Behaviour:
- Reset (async assert, sync release on csi_clk):
  - byte_idx = 0, shift register = 0.
  - aso_out0_valid = 0, aso_out0_data = 0.
  - stat_words = 0, state = IDLE.
  - While rsi_reset is high: slrd_n = 1 and sloe_n = 1.
- sloe_n = 0 whenever reset is not asserted. The FX2LP owns FD continuously.
- States:
  - IDLE (byte_idx = 0, no partial word).
  - ACC (1–3 bytes held).
  - STALL (4th byte pending but output slot blocked); STALL is purely combinational gating, not a registered state.
- Output slot free, combinational: slot_free = ~aso_out0_valid | aso_out0_ready.
- Read enable, combinational:
  - rd_en = coe_fx2lp_flaga_n & (byte_idx != 3 | slot_free).
  - coe_fx2lp_slrd_n = ~rd_en.
- On each rising edge with rd_en = 1:
  - coe_fx2lp_fd is captured into byte lane byte_idx.
  - byte_idx increments and wraps from 3 to 0.
  - IDLE moves to ACC on the first byte; the capture of lane 3 returns to IDLE.
- Word completion, on the edge capturing lane 3:
  - aso_out0_data <= {fd, lanes 2..0}; aso_out0_valid <= 1; stat_words += 1.
  - Latency: the word is valid the cycle after its 4th byte strobe.
- Handshake:
  - A word transfers on an edge with valid & ready.
  - If no new word completes on that edge, valid <= 0.
  - If one does, valid stays 1 with the new data: back-to-back words with no bubble.
  - Data and valid are held stable while valid & ~ready.
- Empty mid-word:
  - When flaga_n = 0, reads pause and byte_idx and partial lanes are held indefinitely.
  - Reading resumes when flaga_n returns to 1, with no byte loss.
- Backpressure:
  - Lanes 0–2 may still be read while the output is blocked.
  - The lane-3 read is withheld until slot_free.
  - Maximum buffering is therefore 1 output word plus 3 bytes.
- Simultaneous events: the same-edge output consume and lane-3 capture is legal and loads the new word.
- Reset mid-word: the partial word is discarded and byte_idx = 0. Host-side realignment is the firmware's concern.
- stat_words wraps modulo 2^COUNT_WIDTH.
- Throughput: 1 byte per clock when not empty and not blocked, i.e. 1 word per 4 clocks.

Test Plan:
- Reset, flaga_n = 1, ready = 1; FD sequence 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88 -> words 0x44332211 then 0x88776655; valid 1 cycle after the 4th/8th strobe; stat_words = 2; slrd_n low 8 consecutive cycles.
- flaga_n = 0 after 2 bytes (0xAA, 0xBB) for 5 cycles, then 1 with 0xCC, 0xDD -> slrd_n high for exactly those 5 cycles; output 0xDDCCBBAA; no valid during the pause.
- ready = 0 held, 8 bytes available -> first word 0x04030201 stays valid and stable; bytes 5–7 read; slrd_n high before byte 8. Raising ready -> first word consumed, byte 8 read on the same edge, second word valid the next cycle.
- Continuous stream with ready toggling 1,0,1,0 -> every word delivered exactly once, in order; stat_words equals the number of valid&ready handshakes.
- Assert rsi_reset asynchronously (between edges) after 3 bytes -> valid = 0, slrd_n = 1, sloe_n = 1 immediately. After release, the next 4 bytes 0x01..0x04 form 0x04030201 with no stale lanes.
- Static outputs -> fifoadr = 2'b10, slwr_n = 1, pktend_n = 1 throughout all tests; stat_words wrap checked with COUNT_WIDTH = 4 after 16 words -> 0.
